// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main controller for the MIPS R3000 core: sequences fetch, decode, execute,
// memory and write-back over one shared ALU, one unified memory port and the register file.
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic             jr_i,
    input  logic             cond_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             iord_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             alu_src_a_o,
    output logic [2:0]       alu_src_b_o,
    output logic [4:0]       alu_op_o,
    output logic             reg_write_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             halt_o,
    output logic             illegal_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WB = 4'd5,
        S_MEM_WR = 4'd6,
        S_ALU_WB = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [4:0] ALU_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_ADD   = 5'b00001;
    localparam logic [4:0] ALU_ADDU  = 5'b00010;
    localparam logic [4:0] ALU_AND   = 5'b00100;
    localparam logic [4:0] ALU_OR    = 5'b00101;
    localparam logic [4:0] ALU_SLT   = 5'b01001;
    localparam logic [4:0] ALU_EQ    = 5'b01101;
    localparam logic [4:0] ALU_NE    = 5'b01110;
    localparam logic [4:0] ALU_LUI   = 5'b10001;

    state_t           r_state;
    logic             r_rst_q;
    logic             r_halt;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retire;

    state_t w_next;
    logic   w_retire;
    logic   w_illegal_op;
    logic   w_is_r;
    logic   w_unused;

    assign w_is_r = (opcode_i == OP_RTYPE);
    // funct is decoded by the ALU control decoder; only its jr flag comes back here.
    assign w_unused = ^funct_i;

    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        w_illegal_op = 1'b0;
        case (r_state)
            // Held one extra edge after reset release so FETCH starts on the second edge.
            S_IDLE:   w_next = r_rst_q ? S_IDLE : S_FETCH;
            S_FETCH:  if (mem_ready_i) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ADDIU,
                    OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: w_next = S_EXEC;
                    OP_BEQ, OP_BNE:                   w_next = S_BRANCH;
                    OP_J, OP_JAL:                     w_next = S_JUMP;
                    OP_HALT:                          w_next = S_HALT;
                    default: begin
                        w_next       = S_HALT;
                        w_illegal_op = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                if (w_is_r && jr_i) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (opcode_i == OP_LW) begin
                    w_next = S_MEM_RD;
                end else if (opcode_i == OP_SW) begin
                    w_next = S_MEM_WR;
                end else begin
                    w_next = S_ALU_WB;
                end
            end
            S_MEM_RD: if (mem_ready_i) w_next = S_MEM_WB;
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_rst_q   <= 1'b1;
            r_halt    <= 1'b0;
            r_illegal <= 1'b0;
            r_retire  <= '0;
        end else begin
            r_state <= w_next;
            r_rst_q <= 1'b0;
            if (w_retire) r_retire <= r_retire + CNT_W'(1);
            if (r_state == S_DECODE && w_next == S_HALT) begin
                r_halt    <= 1'b1;
                r_illegal <= w_illegal_op;
            end
        end
    end

    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'b00;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 3'b000;
        alu_op_o     = 5'b00000;
        reg_write_o  = 1'b0;
        reg_dst_o    = 2'b00;
        mem_to_reg_o = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = 3'b001;
                alu_op_o    = ALU_ADD;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b_o = 3'b100;
                alu_op_o    = ALU_ADD;
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                case (opcode_i)
                    OP_RTYPE: begin
                        alu_src_b_o = 3'b000;
                        alu_op_o    = ALU_RTYPE;
                        if (jr_i) begin
                            pc_write_o = 1'b1;
                            pc_src_o   = 2'b11;
                        end
                    end
                    OP_LW, OP_SW, OP_ADDI: begin alu_src_b_o = 3'b010; alu_op_o = ALU_ADD;  end
                    OP_ADDIU:              begin alu_src_b_o = 3'b010; alu_op_o = ALU_ADDU; end
                    OP_SLTI:               begin alu_src_b_o = 3'b010; alu_op_o = ALU_SLT;  end
                    OP_ANDI:               begin alu_src_b_o = 3'b011; alu_op_o = ALU_AND;  end
                    OP_ORI:                begin alu_src_b_o = 3'b011; alu_op_o = ALU_OR;   end
                    OP_LUI:                begin alu_src_b_o = 3'b011; alu_op_o = ALU_LUI;  end
                    default: ;
                endcase
            end
            S_MEM_RD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'b01;
            end
            S_MEM_WR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                iord_o    = 1'b1;
            end
            S_ALU_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = w_is_r ? 2'b01 : 2'b00;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = (opcode_i == OP_BEQ) ? ALU_EQ : ALU_NE;
                pc_write_o  = cond_i;
                pc_src_o    = 2'b01;
            end
            S_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'b10;
                if (opcode_i == OP_JAL) begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = 2'b10;
                    mem_to_reg_o = 2'b10;
                end
            end
            default: ;
        endcase
    end

    assign halt_o       = r_halt;
    assign illegal_o    = r_illegal;
    assign state_o      = r_state;
    assign retire_cnt_o = r_retire;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: per-instruction model of the state path, pulse counts,
// write-back selects and retire count, with a memory that inserts programmable wait cycles.
module tb_mc_ctrl_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    opcode, funct;
    logic          jr, cond, mem_ready;
    logic          mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
    logic [1:0]    pc_src_o, reg_dst_o, mem_to_reg_o;
    logic          alu_src_a_o, reg_write_o, halt_o, illegal_o;
    logic [2:0]    alu_src_b_o;
    logic [4:0]    alu_op_o;
    logic [3:0]    state_o;
    logic [CW-1:0] retire_cnt_o;

    int n_chk = 0;
    int n_fail = 0;
    int exp_retire = 0;
    int wcnt = 0;

    mc_ctrl_fsm #(.CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct), .jr_i(jr),
        .cond_i(cond), .mem_ready_i(mem_ready), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .iord_o(iord_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
        .halt_o(halt_o), .illegal_o(illegal_o), .state_o(state_o), .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: answers after w cycles of a held request; random ready when idle.
    task automatic cycle_drive(input int wf, input int wm);
        int w;
        @(negedge clk);
        if (mem_req_o) begin
            w = iord_o ? wm : wf;
            mem_ready = (wcnt >= w);
            if (mem_ready) wcnt = 0;
            else wcnt++;
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
            wcnt = 0;
        end
        #1;
    endtask

    task automatic assert_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_state", 32'(state_o), 0);
        chk("rst_mem_req", 32'(mem_req_o), 0);
        chk("rst_pc_write", 32'(pc_write_o), 0);
        chk("rst_retire", 32'(retire_cnt_o), 0);
        chk("rst_halt", 32'(halt_o), 0);
        chk("rst_illegal", 32'(illegal_o), 0);
        exp_retire = 0;
        wcnt = 0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk("rel_idle", 32'(state_o), 0);
        @(posedge clk);
        #1 chk("rel_fetch", 32'(state_o), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        assert_reset();
        release_reset();
    endtask

    function automatic logic [7:0] exec_sel(input logic [5:0] op);
        case (op)
            6'h00:                return {3'b000, 5'b00000};
            6'h23, 6'h2B, 6'h08:  return {3'b010, 5'b00001};
            6'h09:                return {3'b010, 5'b00010};
            6'h0A:                return {3'b010, 5'b01001};
            6'h0C:                return {3'b011, 5'b00100};
            6'h0D:                return {3'b011, 5'b00101};
            default:              return {3'b011, 5'b10001};
        endcase
    endfunction

    // Starts just after the edge that entered FETCH; ends just after the edge back into FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic j,
                             input logic c, input int wf, input int wm);
        int q[$];
        bit is_lw, is_sw, is_r, is_jr, is_br, is_j, is_imm;
        int e_pcw, e_regw, e_mreq, e_mwe, e_iord;
        int o_ir, o_pcw, o_regw, o_mreq, o_mwe, o_iord;
        logic [3:0] e_wb;
        opcode = op; funct = fn; jr = j; cond = c;
        is_lw = (op == 6'h23); is_sw = (op == 6'h2B); is_r = (op == 6'h00);
        is_jr = is_r && j; is_br = (op == 6'h04) || (op == 6'h05);
        is_j = (op == 6'h02) || (op == 6'h03);
        is_imm = !is_lw && !is_sw && !is_r && !is_br && !is_j;
        repeat (wf + 1) q.push_back(1);
        q.push_back(2);
        if (is_lw) begin q.push_back(3); repeat (wm + 1) q.push_back(4); q.push_back(5); end
        else if (is_sw) begin q.push_back(3); repeat (wm + 1) q.push_back(6); end
        else if (is_jr) q.push_back(3);
        else if (is_br) q.push_back(8);
        else if (is_j) q.push_back(9);
        else begin q.push_back(3); q.push_back(7); end
        e_pcw  = 1 + int'(is_jr) + int'(is_br && c) + int'(is_j);
        e_regw = int'(is_lw || (is_r && !j) || is_imm || op == 6'h03);
        e_mreq = 1 + wf + ((is_lw || is_sw) ? 1 + wm : 0);
        e_iord = (is_lw || is_sw) ? 1 + wm : 0;
        e_mwe  = is_sw ? 1 + wm : 0;
        e_wb   = is_lw ? 4'b0001 : (is_r ? 4'b0100 : (op == 6'h03 ? 4'b1010 : 4'b0000));
        o_ir = 0; o_pcw = 0; o_regw = 0; o_mreq = 0; o_mwe = 0; o_iord = 0;
        foreach (q[i]) begin
            cycle_drive(wf, wm);
            chk("state", 32'(state_o), 32'(q[i]));
            o_ir += int'(ir_write_o); o_pcw += int'(pc_write_o); o_regw += int'(reg_write_o);
            o_mreq += int'(mem_req_o); o_mwe += int'(mem_we_o); o_iord += int'(iord_o);
            if (ir_write_o) begin
                chk("fetch_pc_src", 32'(pc_src_o), 0);
                chk("fetch_alu_op", 32'(alu_op_o), 1);
            end
            if (reg_write_o) chk("wb_sel", 32'({reg_dst_o, mem_to_reg_o}), 32'(e_wb));
            if (q[i] == 3) chk("exec_sel", 32'({alu_src_b_o, alu_op_o}), 32'(exec_sel(op)));
            if (q[i] == 3 && is_jr) chk("jr_pc", 32'({pc_write_o, pc_src_o}), 32'h7);
            if (q[i] == 8) chk("br_sel", 32'({alu_op_o, pc_write_o, pc_src_o}),
                               32'({(op == 6'h04) ? 5'b01101 : 5'b01110, c, 2'b01}));
            if (q[i] == 9) chk("jmp_pc", 32'({pc_write_o, pc_src_o}), 32'h6);
        end
        @(posedge clk);
        #1;
        exp_retire = (exp_retire + 1) % (1 << CW);
        chk("end_fetch", 32'(state_o), 1);
        chk("retire", 32'(retire_cnt_o), 32'(exp_retire));
        chk("n_ir_write", 32'(o_ir), 1);
        chk("n_pc_write", 32'(o_pcw), 32'(e_pcw));
        chk("n_reg_write", 32'(o_regw), 32'(e_regw));
        chk("n_mem_req", 32'(o_mreq), 32'(e_mreq));
        chk("n_iord", 32'(o_iord), 32'(e_iord));
        chk("n_mem_we", 32'(o_mwe), 32'(e_mwe));
    endtask

    task automatic run_halt(input logic [5:0] op, input logic exp_ill, input int wf);
        int o_wr;
        opcode = op;
        for (int i = 0; i < wf + 2; i++) begin
            cycle_drive(wf, 0);
            chk("halt_path", 32'(state_o), (i < wf + 1) ? 1 : 2);
            chk("halt_pre", 32'(halt_o), 0);
        end
        @(posedge clk);
        #1;
        chk("halt_state", 32'(state_o), 10);
        chk("halt_o", 32'(halt_o), 1);
        chk("illegal_o", 32'(illegal_o), 32'(exp_ill));
        o_wr = 0;
        repeat (4) begin
            cycle_drive(0, 0);
            o_wr += int'(pc_write_o) + int'(ir_write_o) + int'(reg_write_o) + int'(mem_req_o);
        end
        chk("halt_no_writes", 32'(o_wr), 0);
        chk("halt_sticky", 32'({halt_o, state_o}), 32'h1A);
        chk("halt_retire", 32'(retire_cnt_o), 32'(exp_retire));
    endtask

    initial begin
        logic [5:0] ops [13];
        logic [5:0] op;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F,
                6'h04, 6'h05, 6'h02, 6'h03};
        rst = 1'b1; opcode = '0; funct = '0; jr = 1'b0; cond = 1'b0; mem_ready = 1'b0;
        do_reset();
        run_instr(6'h08, 6'h05, 1'b0, 1'b0, 0, 0);
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 3, 3);
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, 0, 0);
        run_instr(6'h05, 6'h00, 1'b0, 1'b1, 0, 0);
        run_instr(6'h00, 6'h08, 1'b1, 1'b0, 0, 0);
        run_instr(6'h03, 6'h00, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 60; k++) begin
            op = ops[$urandom_range(0, 12)];
            run_instr(op, 6'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        run_halt(6'h3F, 1'b0, 1);
        do_reset();
        run_halt(6'h3E, 1'b1, 0);
        do_reset();
        run_halt(6'h11, 1'b1, 2);
        do_reset();
        run_instr(6'h0D, 6'h00, 1'b0, 1'b0, 0, 0);
        opcode = 6'h2B; jr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle_drive(0, 6);
            chk("sw_path", 32'(state_o), (i < 3) ? i + 1 : 6);
        end
        chk("sw_wait_req", 32'({mem_req_o, mem_we_o, iord_o}), 32'h7);
        chk("sw_wait_retire", 32'(retire_cnt_o), 1);
        assert_reset();
        release_reset();
        chk("post_rst_retire", 32'(retire_cnt_o), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
